// File: rtl/sd_dir_entry_parser.sv
// Streaming FAT16/FAT32 directory-entry parser: frames 32-byte entries, assembles
// and validates LFN sequences, and reports each eligible short entry with its name.
module sd_dir_entry_parser #(
  parameter int NAME_MAX    = 64,
  parameter bit FAT32       = 1'b1,
  parameter bit REPORT_DIRS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dir_start,
  input  logic                  rvalid,
  input  logic [4:0]            raddr,
  input  logic [7:0]            rdata,
  output logic                  fready,
  output logic [8*NAME_MAX-1:0] fname,
  output logic [7:0]            fnamelen,
  output logic                  ftrunc,
  output logic [31:0]           fcluster,
  output logic [31:0]           fsize,
  output logic [7:0]            fattr,
  output logic                  fisdir,
  output logic                  flfn,
  output logic [15:0]           fidx,
  output logic                  dir_end
);

  typedef enum logic [1:0] {S_NONE, S_LFN, S_WAIT_SFN} lfn_st_e;

  localparam logic [8:0] NM = 9'(NAME_MAX);

  logic [31:0][7:0]         buf_q, buf_d;
  logic                     in_q, in_d;
  logic [4:0]               exp_q, exp_d;
  logic                     fbad_q, fbad_d;
  lfn_st_e                  st_q, st_d;
  logic [5:0]               ord_q, ord_d;
  logic [7:0]               chk_q, chk_d;
  logic [7:0]               llen_q, llen_d;
  logic                     lbad_q, lbad_d;
  logic [NAME_MAX-1:0][7:0] lname_q, lname_d;
  logic                     fready_q, fready_d;
  logic [NAME_MAX-1:0][7:0] fname_q, fname_d;
  logic [7:0]               fnamelen_q, fnamelen_d;
  logic                     ftrunc_q, ftrunc_d;
  logic [31:0]              fcluster_q, fcluster_d;
  logic [31:0]              fsize_q, fsize_d;
  logic [7:0]               fattr_q, fattr_d;
  logic                     flfn_q, flfn_d;
  logic [15:0]              fidx_q, fidx_d;
  logic                     pend_q, pend_d;
  logic                     dir_end_q, dir_end_d;

  logic [31:0][7:0] e;
  logic [7:0]       chk_calc;
  logic [11:0][7:0] sfn;
  logic [3:0]       sfn_len;
  logic [12:0][15:0] ch;
  logic             tfound, fbad;
  logic [3:0]       tk;
  logic [8:0]       base, full13;
  logic             report_ok, use_lfn, start_ok, cont_ok;
  logic             close_ok;
  logic             unused_bytes;

  function automatic logic [4:0] lfn_off(input logic [3:0] k);
    case (k)
      4'd0:    return 5'd1;
      4'd1:    return 5'd3;
      4'd2:    return 5'd5;
      4'd3:    return 5'd7;
      4'd4:    return 5'd9;
      4'd5:    return 5'd14;
      4'd6:    return 5'd16;
      4'd7:    return 5'd18;
      4'd8:    return 5'd20;
      4'd9:    return 5'd22;
      4'd10:   return 5'd24;
      4'd11:   return 5'd28;
      4'd12:   return 5'd30;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic [7:0] fold_upper(input logic [15:0] c);
    if (c[15:8] == 8'h00 && c[7:0] >= 8'h61 && c[7:0] <= 8'h7A) return c[7:0] - 8'h20;
    return c[7:0];
  endfunction

  // Entry view at the closing beat: bytes 0..30 buffered, byte 31 on the bus.
  always_comb begin
    logic [7:0] sum;
    logic [7:0] b;
    logic [3:0] n;
    logic [4:0] o;
    e     = buf_q;
    e[31] = rdata;
    sum   = 8'h00;
    for (int i = 0; i < 11; i++) begin
      b   = (i == 0 && e[0] == 8'h05) ? 8'hE5 : e[i];
      sum = {sum[0], sum[7:1]} + b;
    end
    chk_calc = sum;

    sfn = '0;
    n   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (e[i] != 8'h20) begin
        sfn[n] = (i == 0 && e[0] == 8'h05) ? 8'hE5 : e[i];
        n      = n + 4'd1;
      end
    end
    if (e[8] != 8'h20 || e[9] != 8'h20 || e[10] != 8'h20) begin
      sfn[n] = 8'h2E;
      n      = n + 4'd1;
    end
    for (int i = 8; i < 11; i++) begin
      if (e[i] != 8'h20) begin
        sfn[n] = e[i];
        n      = n + 4'd1;
      end
    end
    sfn_len = n;

    tfound = 1'b0;
    tk     = 4'd0;
    fbad   = 1'b0;
    for (int k = 0; k < 13; k++) begin
      o     = lfn_off(4'(k));
      ch[k] = {e[o + 5'd1], e[o]};
      if (!tfound) begin
        if (ch[k] == 16'h0000) begin
          tfound = 1'b1;
          tk     = 4'(k);
        end else if (ch[k] != 16'hFFFF && ch[k][15:8] != 8'h00) begin
          fbad = 1'b1;
        end
      end
    end
    base   = ({3'b0, e[0][5:0]} - 9'd1) * 9'd13;
    full13 = {3'b0, e[0][5:0]} * 9'd13;

    start_ok  = e[0][6] && e[0][5:0] != 6'd0 && e[0][5:0] <= 6'd19;
    cont_ok   = st_q == S_LFN && !e[0][6] && e[0][5:0] == ord_q - 6'd1 && e[13] == chk_q;
    report_ok = e[0] != 8'h00 && e[0] != 8'hE5 && e[11] != 8'h0F && !e[11][3] &&
                e[0] != 8'h2E && (!e[11][4] || REPORT_DIRS);
    use_lfn   = st_q == S_WAIT_SFN && chk_calc == chk_q && !lbad_q;
    // NT flags and timestamps play no part in the report.
    unused_bytes = ^{e[12], e[25:22]};
  end

  always_comb begin
    buf_d      = buf_q;
    in_d       = in_q;
    exp_d      = exp_q;
    fbad_d     = fbad_q;
    st_d       = st_q;
    ord_d      = ord_q;
    chk_d      = chk_q;
    llen_d     = llen_q;
    lbad_d     = lbad_q;
    lname_d    = lname_q;
    fready_d   = 1'b0;
    fname_d    = fname_q;
    fnamelen_d = fnamelen_q;
    ftrunc_d   = ftrunc_q;
    fcluster_d = fcluster_q;
    fsize_d    = fsize_q;
    fattr_d    = fattr_q;
    flfn_d     = flfn_q;
    fidx_d     = fidx_q;
    pend_d     = pend_q;
    dir_end_d  = dir_end_q;
    close_ok   = 1'b0;

    if (dir_start) begin
      in_d      = 1'b0;
      fbad_d    = 1'b0;
      st_d      = S_NONE;
      fidx_d    = 16'd0;
      pend_d    = 1'b0;
      dir_end_d = 1'b0;
    end else begin
      // A reported entry keeps its own index visible for the fready cycle.
      if (pend_q) begin
        fidx_d = fidx_q + 16'd1;
        pend_d = 1'b0;
      end
      if (rvalid && !dir_end_q) begin
        buf_d[raddr] = rdata;
        if (raddr == 5'd0) begin
          in_d   = 1'b1;
          fbad_d = 1'b0;
          exp_d  = 5'd1;
        end else if (in_q) begin
          exp_d = raddr + 5'd1;
          if (raddr != exp_q) fbad_d = 1'b1;
          if (raddr == 5'h1F) begin
            in_d = 1'b0;
            if (fbad_q || raddr != exp_q) st_d = S_NONE;
            else close_ok = 1'b1;
          end
        end
      end

      if (close_ok) begin
        if (report_ok) begin
          pend_d   = 1'b1;
          fready_d = 1'b1;
          fname_d  = '0;
          if (use_lfn) begin
            for (int p = 0; p < NAME_MAX; p++)
              if (9'(p) < {1'b0, llen_q}) fname_d[p] = lname_q[p];
          end else begin
            for (int p = 0; p < 12; p++)
              if (4'(p) < sfn_len) fname_d[p] = sfn[p];
          end
          fnamelen_d = use_lfn ? (({1'b0, llen_q} > NM) ? NM[7:0] : llen_q) : {4'b0, sfn_len};
          ftrunc_d   = use_lfn && ({1'b0, llen_q} > NM);
          fcluster_d = {(FAT32 ? {e[21], e[20]} : 16'h0000), e[27], e[26]};
          fsize_d    = {e[31], e[30], e[29], e[28]};
          fattr_d    = e[11];
          flfn_d     = use_lfn;
        end else begin
          fidx_d = fidx_q + 16'd1;
        end

        if (e[0] == 8'h00) begin
          dir_end_d = 1'b1;
        end else if (e[0] == 8'hE5 || e[11] != 8'h0F) begin
          st_d = S_NONE;
        end else if (cont_ok || start_ok) begin
          for (int p = 0; p < NAME_MAX; p++)
            for (int k = 0; k < 13; k++)
              if (9'(p) == base + 9'(k)) lname_d[p] = fold_upper(ch[k]);
          ord_d = e[0][5:0];
          st_d  = (e[0][5:0] == 6'd1) ? S_WAIT_SFN : S_LFN;
          if (cont_ok) begin
            lbad_d = lbad_q | fbad;
          end else begin
            chk_d  = e[13];
            lbad_d = fbad;
            llen_d = tfound ? 8'(base + {5'b0, tk}) : 8'(full13);
          end
        end else begin
          st_d = S_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      in_q       <= 1'b0;
      exp_q      <= 5'd0;
      fbad_q     <= 1'b0;
      st_q       <= S_NONE;
      ord_q      <= 6'd0;
      chk_q      <= 8'h00;
      llen_q     <= 8'd0;
      lbad_q     <= 1'b0;
      lname_q    <= '0;
      fready_q   <= 1'b0;
      fname_q    <= '0;
      fnamelen_q <= 8'd0;
      ftrunc_q   <= 1'b0;
      fcluster_q <= 32'd0;
      fsize_q    <= 32'd0;
      fattr_q    <= 8'h00;
      flfn_q     <= 1'b0;
      fidx_q     <= 16'd0;
      pend_q     <= 1'b0;
      dir_end_q  <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      in_q       <= in_d;
      exp_q      <= exp_d;
      fbad_q     <= fbad_d;
      st_q       <= st_d;
      ord_q      <= ord_d;
      chk_q      <= chk_d;
      llen_q     <= llen_d;
      lbad_q     <= lbad_d;
      lname_q    <= lname_d;
      fready_q   <= fready_d;
      fname_q    <= fname_d;
      fnamelen_q <= fnamelen_d;
      ftrunc_q   <= ftrunc_d;
      fcluster_q <= fcluster_d;
      fsize_q    <= fsize_d;
      fattr_q    <= fattr_d;
      flfn_q     <= flfn_d;
      fidx_q     <= fidx_d;
      pend_q     <= pend_d;
      dir_end_q  <= dir_end_d;
    end
  end

  assign fready   = fready_q;
  assign fname    = fname_q;
  assign fnamelen = fnamelen_q;
  assign ftrunc   = ftrunc_q;
  assign fcluster = fcluster_q;
  assign fsize    = fsize_q;
  assign fattr    = fattr_q;
  assign fisdir   = fattr_q[4];
  assign flfn     = flfn_q;
  assign fidx     = fidx_q;
  assign dir_end  = dir_end_q;

endmodule

// File: tb/tb_sd_dir_entry_parser.sv
// Directed bench for sd_dir_entry_parser: short names, LFN assembly, skipped
// entries, truncation, end-of-directory, misframing and mid-entry reset.
module tb_sd_dir_entry_parser;

  localparam int NM = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dir_start = 1'b0;
  logic          rvalid = 1'b0;
  logic [4:0]    raddr = 5'd0;
  logic [7:0]    rdata = 8'h00;
  logic          fready;
  logic [8*NM-1:0] fname;
  logic [7:0]    fnamelen;
  logic          ftrunc;
  logic [31:0]   fcluster;
  logic [31:0]   fsize;
  logic [7:0]    fattr;
  logic          fisdir;
  logic          flfn;
  logic [15:0]   fidx;
  logic          dir_end;

  int passed = 0;
  int total = 0;
  int frdy_cnt = 0;
  logic [7:0] ent [32];
  int offs [13] = '{1, 3, 5, 7, 9, 14, 16, 18, 20, 22, 24, 28, 30};

  sd_dir_entry_parser #(.NAME_MAX(NM), .FAT32(1'b1), .REPORT_DIRS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .dir_start(dir_start), .rvalid(rvalid), .raddr(raddr),
    .rdata(rdata), .fready(fready), .fname(fname), .fnamelen(fnamelen), .ftrunc(ftrunc),
    .fcluster(fcluster), .fsize(fsize), .fattr(fattr), .fisdir(fisdir), .flfn(flfn),
    .fidx(fidx), .dir_end(dir_end)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fready === 1'b1) frdy_cnt++;

  function automatic logic [8*NM-1:0] name_vec(input string s);
    logic [8*NM-1:0] v = '0;
    for (int i = 0; i < s.len() && i < NM; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  function automatic logic [7:0] sfn_chk(input logic [87:0] nm);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 11; i++) s = {s[0], s[7:1]} + nm[87-8*i -: 8];
    return s;
  endfunction

  task automatic clear_ent();
    for (int i = 0; i < 32; i++) ent[i] = 8'h00;
  endtask

  task automatic set_sfn(input logic [87:0] nm, input logic [7:0] attr, input logic [15:0] chi,
                         input logic [15:0] clo, input logic [31:0] sz);
    clear_ent();
    for (int i = 0; i < 11; i++) ent[i] = nm[87-8*i -: 8];
    ent[11] = attr;
    ent[20] = chi[7:0];  ent[21] = chi[15:8];
    ent[26] = clo[7:0];  ent[27] = clo[15:8];
    ent[28] = sz[7:0];   ent[29] = sz[15:8];  ent[30] = sz[23:16];  ent[31] = sz[31:24];
  endtask

  task automatic set_lfn(input logic [7:0] ordb, input logic [7:0] ck, input string s);
    int b;
    int idx;
    logic [15:0] c;
    clear_ent();
    ent[0]  = ordb;
    ent[11] = 8'h0F;
    ent[13] = ck;
    b = (int'(ordb & 8'h3F) - 1) * 13;
    for (int k = 0; k < 13; k++) begin
      idx = b + k;
      if (idx < s.len()) c = {8'h00, s[idx]};
      else if (idx == s.len()) c = 16'h0000;
      else c = 16'hFFFF;
      ent[offs[k]]     = c[7:0];
      ent[offs[k] + 1] = c[15:8];
    end
  endtask

  task automatic send_ent();
    for (int i = 0; i < 32; i++) begin
      rvalid = 1'b1; raddr = 5'(i); rdata = ent[i];
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
  endtask

  task automatic pulse_dir_start();
    dir_start = 1'b1;
    @(posedge clk); #1;
    dir_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    total++; if (fready !== 1'b0) $display("FAIL rst_fready: got %b want 0", fready); else passed++;
    total++; if (fname !== '0) $display("FAIL rst_fname: got %h want 0", fname); else passed++;
    total++; if ({fnamelen, ftrunc, flfn, fattr} !== '0) $display("FAIL rst_meta: got %h want 0", {fnamelen, ftrunc, flfn, fattr}); else passed++;
    total++; if ({fcluster, fsize} !== '0) $display("FAIL rst_clus_size: got %h want 0", {fcluster, fsize}); else passed++;
    total++; if ({fidx, dir_end} !== '0) $display("FAIL rst_idx_end: got %h want 0", {fidx, dir_end}); else passed++;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_sfn();
    pulse_dir_start();
    set_sfn({"README", {2{8'h20}}, "TXT"}, 8'h20, 16'h0000, 16'h0003, 32'h0000_0100);
    send_ent();
    total++; if (fready !== 1'b1) $display("FAIL sfn_fready: got %b want 1", fready); else passed++;
    total++; if (fname !== name_vec("README.TXT")) $display("FAIL sfn_name: got %h want %h", fname, name_vec("README.TXT")); else passed++;
    total++; if (fnamelen !== 8'd10) $display("FAIL sfn_len: got %0d want 10", fnamelen); else passed++;
    total++; if (fcluster !== 32'd3) $display("FAIL sfn_cluster: got %h want 3", fcluster); else passed++;
    total++; if (fsize !== 32'd256) $display("FAIL sfn_size: got %0d want 256", fsize); else passed++;
    total++; if ({flfn, ftrunc, fisdir} !== 3'b000) $display("FAIL sfn_flags: got %b want 000", {flfn, ftrunc, fisdir}); else passed++;
    total++; if (fattr !== 8'h20) $display("FAIL sfn_attr: got %h want 20", fattr); else passed++;
    total++; if (fidx !== 16'd0) $display("FAIL sfn_idx: got %0d want 0", fidx); else passed++;
    idle(1);
    total++; if (fready !== 1'b0) $display("FAIL sfn_pulse_width: got %b want 0", fready); else passed++;
    total++; if (fidx !== 16'd1) $display("FAIL sfn_idx_after: got %0d want 1", fidx); else passed++;
    total++; if (fnamelen !== 8'd10) $display("FAIL sfn_hold: got %0d want 10", fnamelen); else passed++;
  endtask

  task automatic test_lfn(input bit corrupt);
    logic [87:0] sn = "LONGFI~1BIN";
    logic [7:0]  ck = sfn_chk(sn);
    pulse_dir_start();
    set_lfn(8'h42, ck, "LongFileName.bin");
    send_ent();
    set_lfn(8'h01, corrupt ? (ck ^ 8'h01) : ck, "LongFileName.bin");
    send_ent();
    set_sfn(sn, 8'h20, 16'h0001, 16'h1234, 32'h0000_1000);
    send_ent();
    total++; if (fready !== 1'b1) $display("FAIL lfn_fready: got %b want 1", fready); else passed++;
    if (!corrupt) begin
      total++; if (fname !== name_vec("LONGFILENAME.BIN")) $display("FAIL lfn_name: got %h want %h", fname, name_vec("LONGFILENAME.BIN")); else passed++;
      total++; if (fnamelen !== 8'd16) $display("FAIL lfn_len: got %0d want 16", fnamelen); else passed++;
      total++; if (flfn !== 1'b1) $display("FAIL lfn_flag: got %b want 1", flfn); else passed++;
      total++; if (fcluster !== 32'h0001_1234) $display("FAIL lfn_cluster: got %h want 00011234", fcluster); else passed++;
      total++; if (fidx !== 16'd2) $display("FAIL lfn_idx: got %0d want 2", fidx); else passed++;
    end else begin
      total++; if (fname !== name_vec("LONGFI~1.BIN")) $display("FAIL badchk_name: got %h want %h", fname, name_vec("LONGFI~1.BIN")); else passed++;
      total++; if (fnamelen !== 8'd12) $display("FAIL badchk_len: got %0d want 12", fnamelen); else passed++;
      total++; if (flfn !== 1'b0) $display("FAIL badchk_flag: got %b want 0", flfn); else passed++;
    end
  endtask

  task automatic test_skipped();
    int c0;
    pulse_dir_start();
    c0 = frdy_cnt;
    set_sfn({8'hE5, "LDFILE", 8'h20, "TXT"}, 8'h20, 16'h0, 16'h0005, 32'd10);
    send_ent();
    set_sfn({8'h2E, {10{8'h20}}}, 8'h10, 16'h0, 16'h0006, 32'd0);
    send_ent();
    set_sfn({"MYDISK", {5{8'h20}}}, 8'h08, 16'h0, 16'h0000, 32'd0);
    send_ent();
    set_sfn({"SUBDIR", {5{8'h20}}}, 8'h10, 16'h0, 16'h0007, 32'd0);
    send_ent();
    idle(2);
    total++; if (frdy_cnt !== c0) $display("FAIL skip_fready: got %0d pulses want 0", frdy_cnt - c0); else passed++;
    total++; if (fidx !== 16'd4) $display("FAIL skip_idx: got %0d want 4", fidx); else passed++;
    total++; if (fnamelen !== 8'd12) $display("FAIL skip_hold: got %0d want 12", fnamelen); else passed++;
  endtask

  task automatic test_trunc();
    string s = "";
    logic [87:0] sn = {"ABCDEF~1", {3{8'h20}}};
    logic [7:0]  ck = sfn_chk(sn);
    for (int r = 0; r < 7; r++) s = {s, "abcdefghij"};
    pulse_dir_start();
    set_lfn(8'h46, ck, s);
    send_ent();
    for (int n = 5; n >= 1; n--) begin
      set_lfn(8'(n), ck, s);
      send_ent();
    end
    set_sfn(sn, 8'h20, 16'h0, 16'h0009, 32'd70);
    send_ent();
    total++; if (fready !== 1'b1) $display("FAIL trunc_fready: got %b want 1", fready); else passed++;
    total++; if (fnamelen !== 8'd64) $display("FAIL trunc_len: got %0d want 64", fnamelen); else passed++;
    total++; if ({ftrunc, flfn} !== 2'b11) $display("FAIL trunc_flags: got %b want 11", {ftrunc, flfn}); else passed++;
    total++; if (fname !== name_vec(s.toupper())) $display("FAIL trunc_name: got %h want %h", fname, name_vec(s.toupper())); else passed++;
    total++; if (fidx !== 16'd6) $display("FAIL trunc_idx: got %0d want 6", fidx); else passed++;
  endtask

  task automatic test_dir_end();
    int c0;
    pulse_dir_start();
    c0 = frdy_cnt;
    clear_ent();
    send_ent();
    set_sfn({"README", {2{8'h20}}, "TXT"}, 8'h20, 16'h0000, 16'h0003, 32'h0000_0100);
    send_ent();
    idle(2);
    total++; if (dir_end !== 1'b1) $display("FAIL end_set: got %b want 1", dir_end); else passed++;
    total++; if (frdy_cnt !== c0) $display("FAIL end_no_fready: got %0d pulses want 0", frdy_cnt - c0); else passed++;
    pulse_dir_start();
    total++; if (dir_end !== 1'b0) $display("FAIL end_clear: got %b want 0", dir_end); else passed++;
    total++; if (fidx !== 16'd0) $display("FAIL end_idx_clear: got %0d want 0", fidx); else passed++;
    send_ent();
    total++; if (fready !== 1'b1) $display("FAIL end_resume: got %b want 1", fready); else passed++;
    total++; if (fidx !== 16'd0) $display("FAIL end_resume_idx: got %0d want 0", fidx); else passed++;
  endtask

  task automatic test_misframe();
    int c0;
    int a;
    pulse_dir_start();
    c0 = frdy_cnt;
    set_sfn({"README", {2{8'h20}}, "TXT"}, 8'h20, 16'h0000, 16'h0003, 32'h0000_0100);
    for (int j = 0; j < 33; j++) begin
      a = (j <= 5) ? j : j - 1;
      rvalid = 1'b1; raddr = 5'(a); rdata = ent[a];
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    idle(2);
    total++; if (frdy_cnt !== c0) $display("FAIL misframe_fready: got %0d pulses want 0", frdy_cnt - c0); else passed++;
    total++; if (fidx !== 16'd0) $display("FAIL misframe_idx: got %0d want 0", fidx); else passed++;
    send_ent();
    send_ent();
    total++; if (fready !== 1'b1) $display("FAIL b2b_fready: got %b want 1", fready); else passed++;
    total++; if (fidx !== 16'd1) $display("FAIL b2b_idx: got %0d want 1", fidx); else passed++;
    total++; if (frdy_cnt - c0 !== 1) $display("FAIL b2b_count: got %0d pulses want 1 before sample", frdy_cnt - c0); else passed++;
  endtask

  task automatic test_reset_mid();
    int c0;
    set_sfn({"README", {2{8'h20}}, "TXT"}, 8'h20, 16'h0000, 16'h0003, 32'h0000_0100);
    for (int i = 0; i < 16; i++) begin
      rvalid = 1'b1; raddr = 5'(i); rdata = ent[i];
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rst_n = 1'b0;
    #2;
    total++; if ({fnamelen, fidx, fcluster} !== '0) $display("FAIL midrst_clear: got %h want 0", {fnamelen, fidx, fcluster}); else passed++;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    c0 = frdy_cnt;
    for (int i = 16; i < 32; i++) begin
      rvalid = 1'b1; raddr = 5'(i); rdata = ent[i];
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    idle(2);
    total++; if (frdy_cnt !== c0) $display("FAIL midrst_fready: got %0d pulses want 0", frdy_cnt - c0); else passed++;
    total++; if (fname !== '0) $display("FAIL midrst_fname: got %h want 0", fname); else passed++;
  endtask

  initial begin
    test_reset();
    test_sfn();
    test_lfn(1'b0);
    test_lfn(1'b1);
    test_skipped();
    test_trunc();
    test_dir_end();
    test_misframe();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
